// File: rtl/tdm_demux4.sv
// tdm_demux4: 4-slot TDM receive demultiplexer locked to a frame-sync marker.
// Optional macro TDM_LOCK_LOSS_EN: drop lock after two consecutive missing syncs.
module tdm_demux4 #(
    parameter int WIDTH = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [WIDTH-1:0]   din,
    input  logic               din_valid,
    input  logic               frame_sync,
    output logic [4*WIDTH-1:0] d_out,
    output logic               frame_valid,
    output logic [1:0]         slot,
    output logic               locked,
    output logic               sync_err
);

    typedef enum logic {
        HUNT   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    state_t                     state, state_n;
    logic [1:0]                 slot_n;
    logic [2:0][WIDTH-1:0]      sh, sh_n;
    logic [4*WIDTH-1:0]         dout_n;
    logic                       fv_n;
    logic                       err_n;
`ifdef TDM_LOCK_LOSS_EN
    logic [1:0]                 miss, miss_n;
`endif

    // State, shadow and output registers; all cleared by synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= HUNT;
            slot        <= 2'd0;
            sh          <= '0;
            d_out       <= '0;
            frame_valid <= 1'b0;
            sync_err    <= 1'b0;
            locked      <= 1'b0;
`ifdef TDM_LOCK_LOSS_EN
            miss        <= 2'd0;
`endif
        end else begin
            state       <= state_n;
            slot        <= slot_n;
            sh          <= sh_n;
            d_out       <= dout_n;
            frame_valid <= fv_n;
            sync_err    <= err_n;
            locked      <= (state_n == LOCKED);
`ifdef TDM_LOCK_LOSS_EN
            miss        <= miss_n;
`endif
        end
    end

    // Next-state: slot tracking, shadow capture and frame transfer.
    always_comb begin
        state_n = state;
        slot_n  = slot;
        sh_n    = sh;
        dout_n  = d_out;
        fv_n    = 1'b0;
        err_n   = 1'b0;
`ifdef TDM_LOCK_LOSS_EN
        miss_n  = miss;
`endif
        if (din_valid) begin
            unique case (state)
                HUNT: begin
                    if (frame_sync) begin
                        sh_n[0] = din;
                        slot_n  = 2'd1;
                        state_n = LOCKED;
`ifdef TDM_LOCK_LOSS_EN
                        miss_n  = 2'd0;
`endif
                    end
                end
                LOCKED: begin
                    if (frame_sync) begin
                        // Sync restarts the frame; off-slot sync drops the partial one.
                        err_n   = (slot != 2'd0);
                        sh_n[0] = din;
                        slot_n  = 2'd1;
`ifdef TDM_LOCK_LOSS_EN
                        miss_n  = 2'd0;
`endif
                    end else begin
                        unique case (slot)
                            2'd0: begin
`ifdef TDM_LOCK_LOSS_EN
                                if (miss != 2'd0) begin
                                    state_n = HUNT;
                                    slot_n  = 2'd0;
                                    miss_n  = 2'd0;
                                end else begin
                                    miss_n  = miss + 2'd1;
                                    sh_n[0] = din;
                                    slot_n  = 2'd1;
                                end
`else
                                sh_n[0] = din;
                                slot_n  = 2'd1;
`endif
                            end
                            2'd1: begin
                                sh_n[1] = din;
                                slot_n  = 2'd2;
                            end
                            2'd2: begin
                                sh_n[2] = din;
                                slot_n  = 2'd3;
                            end
                            2'd3: begin
                                dout_n = {din, sh[2], sh[1], sh[0]};
                                fv_n   = 1'b1;
                                slot_n = 2'd0;
                            end
                        endcase
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tdm_demux4.sv
// tb_tdm_demux4: scoreboard bench for tdm_demux4 (WIDTH=1).
// Expected frames are queued at the slot-3 beat and checked on frame_valid.
module tb_tdm_demux4;

    logic       clk = 1'b0;
    logic       rst;
    logic [0:0] din;
    logic       din_valid;
    logic       frame_sync;
    logic [3:0] d_out;
    logic       frame_valid;
    logic [1:0] slot;
    logic       locked;
    logic       sync_err;

    int         n_cmp = 0;
    int         n_bad = 0;
    int         fv_count = 0;
    int         err_count = 0;
    logic [3:0] exp_q[$];

    tdm_demux4 #(.WIDTH(1)) dut (
        .clk         (clk),
        .rst         (rst),
        .din         (din),
        .din_valid   (din_valid),
        .frame_sync  (frame_sync),
        .d_out       (d_out),
        .frame_valid (frame_valid),
        .slot        (slot),
        .locked      (locked),
        .sync_err    (sync_err)
    );

    always #5 clk = ~clk;

    // Scoreboard monitor: pop and compare on every frame_valid.
    always @(negedge clk) begin
        logic [3:0] e;
        if (rst !== 1'b1) begin
            if (sync_err === 1'b1) err_count++;
            if (frame_valid === 1'b1) begin
                fv_count++;
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_bad++;
                    $display("FAIL unexpected_frame got d_out=%b expected no frame", d_out);
                end else begin
                    e = exp_q.pop_front();
                    if (d_out !== e) begin
                        n_bad++;
                        $display("FAIL frame_data got %b expected %b", d_out, e);
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout got no finish expected finish");
        $fatal(1, "timeout");
    end

    task automatic drive(input logic v, input logic fs, input logic d);
        @(negedge clk);
        din_valid  = v;
        frame_sync = fs;
        din        = d;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 1'b0);
    endtask

    task automatic do_reset(input int cycles);
        @(negedge clk);
        rst = 1'b1;
        din_valid = 1'b0;
        frame_sync = 1'b0;
        din = 1'b0;
        repeat (cycles) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        din_valid = 1'b0;
        frame_sync = 1'b0;
        din = 1'b0;
        repeat (2) @(negedge clk);
        n_cmp++;
        if ({d_out, frame_valid, sync_err, locked, slot} !== 9'd0) begin
            n_bad++;
            $display("FAIL reset_state got d=%b fv=%b se=%b lk=%b sl=%0d expected all 0",
                     d_out, frame_valid, sync_err, locked, slot);
        end
        rst = 1'b0;
    endtask

    task automatic test_basic_frame();
        int f0;
        f0 = fv_count;
        drive(1, 1, 0);
        drive(1, 0, 1);
        n_cmp++;
        if (locked !== 1'b1) begin
            n_bad++;
            $display("FAIL basic_locked got %b expected 1", locked);
        end
        drive(1, 0, 0);
        drive(1, 0, 1);
        exp_q.push_back(4'b1010);
        idle();
        n_cmp++;
        if (frame_valid !== 1'b1) begin
            n_bad++;
            $display("FAIL basic_latency got fv=%b expected 1", frame_valid);
        end
        idle();
        n_cmp++;
        if (frame_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL basic_pulse_width got fv=%b expected 0", frame_valid);
        end
        idle();
        n_cmp++;
        if (fv_count - f0 != 1 || d_out !== 4'b1010) begin
            n_bad++;
            $display("FAIL basic_hold got count=%0d d=%b expected 1 and 1010",
                     fv_count - f0, d_out);
        end
    endtask

    task automatic test_hunt_drop();
        do_reset(1);
        drive(1, 0, 1);
        drive(1, 0, 1);
        idle();
        n_cmp++;
        if (locked !== 1'b0 || slot !== 2'd0) begin
            n_bad++;
            $display("FAIL hunt_drop got lk=%b sl=%0d expected 0 0", locked, slot);
        end
        drive(1, 1, 1);
        drive(1, 0, 1);
        drive(1, 0, 0);
        drive(1, 0, 0);
        exp_q.push_back(4'b0011);
        repeat (2) idle();
    endtask

    task automatic test_gap();
        int f0;
        f0 = fv_count;
        drive(1, 1, 0);
        drive(1, 0, 1);
        for (int i = 0; i < 3; i++) begin
            idle();
            n_cmp++;
            if (slot !== 2'd2) begin
                n_bad++;
                $display("FAIL gap_slot_hold got %0d expected 2", slot);
            end
        end
        drive(1, 0, 0);
        drive(1, 0, 1);
        exp_q.push_back(4'b1010);
        repeat (3) idle();
        n_cmp++;
        if (fv_count - f0 != 1) begin
            n_bad++;
            $display("FAIL gap_frame_count got %0d expected 1", fv_count - f0);
        end
    endtask

    task automatic test_sync_err();
        int e0, f0;
        e0 = err_count;
        f0 = fv_count;
        drive(1, 1, 1);
        drive(1, 0, 1);
        drive(1, 1, 0);
        idle();
        n_cmp++;
        if (sync_err !== 1'b1) begin
            n_bad++;
            $display("FAIL sync_err_pulse got %b expected 1", sync_err);
        end
        drive(1, 0, 1);
        drive(1, 0, 1);
        drive(1, 0, 1);
        exp_q.push_back(4'b1110);
        repeat (3) idle();
        n_cmp++;
        if (err_count - e0 != 1 || fv_count - f0 != 1) begin
            n_bad++;
            $display("FAIL sync_err_counts got err=%0d fv=%0d expected 1 1",
                     err_count - e0, fv_count - f0);
        end
    endtask

    task automatic test_flywheel();
        int f0;
        f0 = fv_count;
        drive(1, 0, 1);
        drive(1, 0, 0);
        drive(1, 0, 0);
        drive(1, 0, 1);
        exp_q.push_back(4'b1001);
        drive(1, 0, 0);
        idle();
`ifdef TDM_LOCK_LOSS_EN
        n_cmp++;
        if (locked !== 1'b0 || slot !== 2'd0) begin
            n_bad++;
            $display("FAIL lock_loss got lk=%b sl=%0d expected 0 0", locked, slot);
        end
        drive(1, 0, 1);
        drive(1, 0, 1);
        drive(1, 0, 0);
        repeat (2) idle();
        n_cmp++;
        if (fv_count - f0 != 1) begin
            n_bad++;
            $display("FAIL lock_loss_frames got %0d expected 1", fv_count - f0);
        end
`else
        drive(1, 0, 1);
        drive(1, 0, 1);
        drive(1, 0, 0);
        exp_q.push_back(4'b0110);
        repeat (2) idle();
        n_cmp++;
        if (locked !== 1'b1 || fv_count - f0 != 2) begin
            n_bad++;
            $display("FAIL flywheel got lk=%b frames=%0d expected 1 2",
                     locked, fv_count - f0);
        end
`endif
    endtask

    task automatic test_reset_mid_frame();
        drive(1, 1, 1);
        drive(1, 0, 1);
        drive(1, 0, 1);
        @(negedge clk);
        rst = 1'b1;
        din_valid = 1'b0;
        frame_sync = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({d_out, frame_valid, sync_err, locked, slot} !== 9'd0) begin
            n_bad++;
            $display("FAIL reset_mid got d=%b fv=%b se=%b lk=%b sl=%0d expected all 0",
                     d_out, frame_valid, sync_err, locked, slot);
        end
        rst = 1'b0;
        drive(1, 1, 1);
        drive(1, 0, 0);
        drive(1, 0, 0);
        drive(1, 0, 0);
        exp_q.push_back(4'b0001);
        repeat (3) idle();
        n_cmp++;
        if (d_out !== 4'b0001) begin
            n_bad++;
            $display("FAIL reset_fresh_frame got %b expected 0001", d_out);
        end
    endtask

    initial begin
        test_reset();
        test_basic_frame();
        test_hunt_drop();
        test_gap();
        test_sync_err();
        test_flywheel();
        test_reset_mid_frame();
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL scoreboard_drain got %0d pending expected 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
